// File: rtl/bep_frame_controller.sv
// Sequencer for the serial BEP frame decoder: captures completed frames, re-arms the decoder
// and keeps saturating statistics. Optional serial-idle timeout is enabled by `BEP_TIMEOUT_EN.
module bep_frame_controller #(
    parameter int SYNC_STAGES    = 2,
    parameter int REARM_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int COUNT_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   serial_clock,
    input  logic                   dec_full,
    input  logic [95:0]            dec_frame,
    output logic                   dec_reset_n,
    output logic                   frame_valid,
    input  logic                   frame_ack,
    output logic [95:0]            frame_data,
    input  logic [3:0]             byte_sel,
    output logic [7:0]             byte_out,
    output logic [COUNT_WIDTH-1:0] frame_count,
    output logic [COUNT_WIDTH-1:0] overrun_count,
    output logic [COUNT_WIDTH-1:0] timeout_count,
    output logic [1:0]             ctrl_state
);

    typedef enum logic [1:0] {
        REARM   = 2'd0,
        SETTLE  = 2'd1,
        ARMED   = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    localparam int RW = $clog2(REARM_CYCLES + 1);

    state_t                   state, next_state;
    logic [RW-1:0]            rearm_cnt;
    logic [SYNC_STAGES-1:0]   full_sync;
    logic                     full_s;
    logic                     timeout_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) full_sync <= '0;
        else       full_sync <= {full_sync[SYNC_STAGES-2:0], dec_full};
    end

    assign full_s = full_sync[SYNC_STAGES-1];

`ifdef BEP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0]   sclk_sync;
    logic                     sclk_s, sclk_prev, serial_edge, seen_edge;
    logic [TW-1:0]            idle_cnt;
    logic [COUNT_WIDTH-1:0]   timeout_q;

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign serial_edge = sclk_s & ~sclk_prev;
    // A frame completing in the same cycle outranks the timeout.
    assign timeout_hit = (state == ARMED) && !full_s && seen_edge && !serial_edge &&
                         (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            sclk_prev <= 1'b0;
            seen_edge <= 1'b0;
            idle_cnt  <= '0;
            timeout_q <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], serial_clock};
            sclk_prev <= sclk_s;
            if (state == SETTLE && next_state == ARMED) begin
                seen_edge <= 1'b0;
                idle_cnt  <= '0;
            end else if (state == ARMED) begin
                if (serial_edge) begin
                    seen_edge <= 1'b1;
                    idle_cnt  <= '0;
                end else if (seen_edge) begin
                    idle_cnt <= timeout_hit ? '0 : idle_cnt + 1'b1;
                end
            end
            if (timeout_hit && timeout_q != '1)
                timeout_q <= timeout_q + 1'b1;
        end
    end

    assign timeout_count = timeout_q;
`else
    assign timeout_hit   = 1'b0;
    assign timeout_count = '0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            REARM:   if (rearm_cnt <= RW'(1)) next_state = SETTLE;
            SETTLE:  if (!full_s) next_state = ARMED;
            ARMED: begin
                if (full_s)           next_state = CAPTURE;
                else if (timeout_hit) next_state = REARM;
            end
            CAPTURE: next_state = REARM;
            default: next_state = REARM;
        endcase
    end

    // dec_reset_n is registered so the decoder's async reset never sees decode glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= REARM;
            rearm_cnt   <= RW'(REARM_CYCLES);
            dec_reset_n <= 1'b0;
        end else begin
            state       <= next_state;
            dec_reset_n <= (next_state != REARM);
            if (next_state == REARM && state != REARM)
                rearm_cnt <= RW'(REARM_CYCLES);
            else if (state == REARM && rearm_cnt != '0)
                rearm_cnt <= rearm_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_data    <= '0;
            frame_valid   <= 1'b0;
            frame_count   <= '0;
            overrun_count <= '0;
        end else if (state == CAPTURE) begin
            frame_data  <= dec_frame;
            frame_valid <= 1'b1;
            if (frame_count != '1)
                frame_count <= frame_count + 1'b1;
            if (frame_valid && !frame_ack && overrun_count != '1)
                overrun_count <= overrun_count + 1'b1;
        end else if (frame_valid && frame_ack) begin
            frame_valid <= 1'b0;
        end
    end

    always_comb begin
        byte_out = '0;
        for (int unsigned i = 0; i < 12; i++) begin
            if (byte_sel == 4'(i))
                byte_out = frame_data[95 - 8*i -: 8];
        end
    end

    assign ctrl_state = state;

endmodule

// File: doc/bep_frame_controller.md
# bep_frame_controller

Sequencer for the serial BEP frame decoder. It runs in the system `clk` domain and watches the decoder's asynchronous `full` flag. When a frame completes, it copies the 96-bit payload into a holding register and hands it to the consumer through a valid/ack handshake. It then re-arms the decoder by pulsing the decoder's active-low reset, and keeps saturating frame, overrun and timeout statistics.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in each async-input synchronizer (minimum 2).
- `REARM_CYCLES`, 4: clk cycles `dec_reset_n` is held low per re-arm (minimum 1).
- `TIMEOUT_CYCLES`, 4096: serial-idle clk cycles before a partial frame is abandoned.
- `COUNT_WIDTH`, 8: width of each statistics counter.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `serial_clock`  in  1  decoder serial clock, async; used for activity detect only.
- `dec_full`  in  1  decoder `full`, async.
- `dec_frame`  in  96  decoder payload {id[31:0], room[15:0], set[15:0], state[7:0], tail1, tail2, tail3}.
- `dec_reset_n`  out  1  drives the decoder `reset_n`.
- `frame_valid`  out  1  holding register holds an unacknowledged frame.
- `frame_ack`  in  1  consumer acknowledge.
- `frame_data`  out  96  holding register.
- `byte_sel`  in  4  readout byte index.
- `byte_out`  out  8  selected byte.
- `frame_count`  out  COUNT_WIDTH  frames captured.
- `overrun_count`  out  COUNT_WIDTH  frames that overwrote an unacked frame.
- `timeout_count`  out  COUNT_WIDTH  partial frames abandoned.
- `ctrl_state`  out  2  current FSM state (debug).

## Operation
- **Synchronization:** `dec_full` and `serial_clock` each pass through a `SYNC_STAGES` synchronizer, giving `full_s` and `sclk_s`.
- **`serial_edge`:** one-cycle pulse on a rising edge of `sclk_s`.
- **FSM state encoding:** REARM=0, SETTLE=1, ARMED=2, CAPTURE=3.
- **REARM:**
  - `dec_reset_n`=0.
  - A down-counter loaded with `REARM_CYCLES` runs; at 0 → SETTLE.
- **SETTLE:**
  - `dec_reset_n`=1.
  - Waits until `full_s`=0, flushing the synchronizer lag; then → ARMED and clears the idle timer and `seen_edge`.
- **ARMED:**
  - `full_s`=1 → CAPTURE.
  - Any `serial_edge` sets `seen_edge` and clears the idle timer.
- **CAPTURE (one cycle):**
  - `frame_data` ← `dec_frame`. The payload is stable because the decoder stops shifting while full.
  - `frame_count` +1, saturating.
  - If `frame_valid`=1 and `frame_ack`=0: `overrun_count` +1, saturating.
  - `frame_valid` ← 1.
  - Next state → REARM.
- **Handshake:**
  - `frame_valid` && `frame_ack` clears `frame_valid` next cycle.
  - If capture and ack fall in the same cycle, capture wins: `frame_valid` stays 1 with the new data and no overrun is counted.
  - `frame_ack` while `frame_valid`=0 is ignored.
- **Byte readout (combinational):**
  - `byte_sel`=n, for n in 0..11, gives `frame_data[95-8n -: 8]`, so 0 is id MSB and 11 is tail3.
  - n in 12..15 gives 0.
- **Counters** saturate at all-ones and never wrap. They are cleared only by `reset`.

## Timing
- **Reset values:**
  - FSM=REARM with the rearm counter = `REARM_CYCLES`.
  - `dec_reset_n`=0, `frame_valid`=0, `frame_data`=0, all counters 0.
  - `ctrl_state`=0 and `byte_out`=0 (because `frame_data`=0).
- After `reset` deasserts, `dec_reset_n` stays 0 for exactly `REARM_CYCLES` clk edges.
- Capture latency: the first clk edge sampling `dec_full`=1, plus `SYNC_STAGES` edges, reaches ARMED→CAPTURE. `frame_valid` rises one edge later, i.e. `SYNC_STAGES`+2 edges total.
- `dec_reset_n` falls on the edge after CAPTURE.
- `reset` asserted mid-frame or mid-rearm returns every register to its reset value immediately. Decoder re-arm follows release.
- A `dec_full` glitch shorter than one clk period may be missed. The decoder holds `full` until re-armed, so this cannot occur in operation.

## Configuration
- `BEP_TIMEOUT_EN` defined:
  - In ARMED with `seen_edge`=1, an idle timer counts clk cycles with no `serial_edge`.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes ARMED→REARM and `timeout_count` +1, saturating.
  - `full_s`=1 in the same cycle takes priority: CAPTURE, no timeout counted.
- `BEP_TIMEOUT_EN` undefined:
  - No idle timer; `serial_clock` is unused.
  - `timeout_count` is constant 0.
  - ARMED exits only via `full_s`.

## Test plan
- Reset then release → `dec_reset_n` low exactly 4 clks; `ctrl_state` reaches 2 after `full_s` clears; all counters 0.
- Drive `dec_frame`=96'h0123_4567_1A2B_1C2D_05_AA_BB_CC and raise `dec_full` → `frame_valid` rises 4 clks later with matching `frame_data`, `frame_count`=1. Then `byte_sel`=0 gives 8'h01, 8 gives 8'h05, 11 gives 8'hCC, 13 gives 8'h00.
- Two frames with no ack → second frame overwrites, `overrun_count`=1, `frame_valid` stays 1. Repeat with `frame_ack`=1 in the CAPTURE cycle → `overrun_count` unchanged.
- 300 frames → `frame_count`=255, holds at 255.
- With `BEP_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: 5 serial edges then idle → re-arm after 16 idle clks, `timeout_count`=1, `frame_valid` unchanged. Without the macro: stays ARMED, `timeout_count`=0.
- Assert `reset` during CAPTURE → `frame_valid`=0, `frame_count`=0, `dec_reset_n`=0 immediately.
